// File: rtl/ksa_pkg.sv
//==============================================================================
// Module      : ksa_pkg
// Description : Shared width/latency constants, the (G,P) pair type and the
//               Kogge-Stone prefix-combine operator for ksa4_pipelined_adder.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package ksa_pkg;

    localparam int KSA_W   = 4;   // operand width
    localparam int KSA_LAT = 4;   // sampling edge to output edge

    // Generate / propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } ksa_gp_t;

    // Prefix operator: hi covers the upper span, lo the span directly below.
    function automatic ksa_gp_t ksa_combine(input ksa_gp_t hi, input ksa_gp_t lo);
        ksa_gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ksa_pulse_capture.sv
//==============================================================================
// Module      : ksa_pulse_capture
// Description : Single-bit pulse-capture cell. A rising edge on pulse_i marks
//               the bit as 1 until the next clk rising edge consumes it.
//               Built as a toggle/acknowledge pair so that each flop has one
//               clock: the pad edge flips tog_q, the clock edge copies it.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module ksa_pulse_capture (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    output logic level_o
);

    logic tog_q;
    logic ack_q;

    // Pad-edge side: each rising edge of the input flips the toggle.
    always_ff @(posedge pulse_i or negedge rst_n) begin
        if (!rst_n) tog_q <= 1'b0;
        else        tog_q <= ~tog_q;
    end

    // Clock side: acknowledge whatever was pending at this edge, clearing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= tog_q;
    end

    assign level_o = tog_q ^ ack_q;

endmodule

`default_nettype wire

// File: rtl/ksa4_pipelined_adder.sv
//==============================================================================
// Module      : ksa4_pipelined_adder
// Description : 4-bit Kogge-Stone adder with carry-in/out, five register
//               stages (capture, p/g, prefix span 1, prefix span 2, output),
//               one new addition per clock, latency of four edges.
//               Build option PULSE_CAPTURE_EN: every data pad goes through a
//               ksa_pulse_capture cell so short pulses count as a 1.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module ksa4_pipelined_adder
    import ksa_pkg::*;
(
    input  logic GCLK_Pad,
    input  logic RST_N_Pad,
    input  logic a0_Pad,
    input  logic a1_Pad,
    input  logic a2_Pad,
    input  logic a3_Pad,
    input  logic b0_Pad,
    input  logic b1_Pad,
    input  logic b2_Pad,
    input  logic b3_Pad,
    input  logic cin_Pad,
    output logic sum0_Pad,
    output logic sum1_Pad,
    output logic sum2_Pad,
    output logic sum3_Pad,
    output logic cout_Pad
);

    logic [KSA_W-1:0] op_a;
    logic [KSA_W-1:0] op_b;
    logic             op_cin;

`ifdef PULSE_CAPTURE_EN
    logic [2*KSA_W:0] pad_raw;
    logic [2*KSA_W:0] pad_cap;

    assign pad_raw = {cin_Pad, b3_Pad, b2_Pad, b1_Pad, b0_Pad,
                      a3_Pad, a2_Pad, a1_Pad, a0_Pad};

    for (genvar i = 0; i <= 2*KSA_W; i++) begin : g_cap
        ksa_pulse_capture u_cap (
            .clk     (GCLK_Pad),
            .rst_n   (RST_N_Pad),
            .pulse_i (pad_raw[i]),
            .level_o (pad_cap[i])
        );
    end

    assign {op_cin, op_b, op_a} = pad_cap;
`else
    assign op_a   = {a3_Pad, a2_Pad, a1_Pad, a0_Pad};
    assign op_b   = {b3_Pad, b2_Pad, b1_Pad, b0_Pad};
    assign op_cin = cin_Pad;
`endif

    // Stage registers
    logic [KSA_W-1:0]          s0_a_q, s0_b_q;
    logic                      s0_cin_q;
    ksa_gp_t [KSA_W-1:0]       s1_gp_d, s1_gp_q;
    logic                      s1_cin_q;
    ksa_gp_t [KSA_W-1:0]       s2_gp_d, s2_gp_q;
    logic [KSA_W-1:0]          s2_p_d, s2_p_q;
    logic                      s2_cin_q;
    ksa_gp_t [KSA_W-1:0]       s3_gp_d, s3_gp_q;
    logic [KSA_W-1:0]          s3_p_q;
    logic                      s3_cin_q;
    logic [KSA_W-1:0]          s4_sum_d, s4_sum_q;
    logic                      s4_cout_d, s4_cout_q;

    // Next-state logic for p/g, both prefix levels and the sum stage.
    always_comb begin
        // S1: bitwise p/g, carry-in folded into bit 0 generate
        for (int i = 0; i < KSA_W; i++) begin
            s1_gp_d[i].p = s0_a_q[i] ^ s0_b_q[i];
            s1_gp_d[i].g = s0_a_q[i] & s0_b_q[i];
        end
        s1_gp_d[0].g = s1_gp_d[0].g | (s1_gp_d[0].p & s0_cin_q);

        // S2: span-1 prefix; bit 0 passes through. Raw p rides along.
        s2_gp_d[0] = s1_gp_q[0];
        for (int i = 1; i < KSA_W; i++) begin
            s2_gp_d[i] = ksa_combine(s1_gp_q[i], s1_gp_q[i-1]);
        end
        for (int i = 0; i < KSA_W; i++) begin
            s2_p_d[i] = s1_gp_q[i].p;
        end

        // S3: span-2 prefix; bits 0..1 pass through
        s3_gp_d[0] = s2_gp_q[0];
        s3_gp_d[1] = s2_gp_q[1];
        for (int i = 2; i < KSA_W; i++) begin
            s3_gp_d[i] = ksa_combine(s2_gp_q[i], s2_gp_q[i-2]);
        end

        // S4: G_{i-1} is the carry into bit i; bit 0 uses the raw carry-in
        s4_sum_d[0] = s3_p_q[0] ^ s3_cin_q;
        for (int i = 1; i < KSA_W; i++) begin
            s4_sum_d[i] = s3_p_q[i] ^ s3_gp_q[i-1].g;
        end
        s4_cout_d = s3_gp_q[KSA_W-1].g;
    end

    // Pipeline registers; reset clears every stage so in-flight work is lost.
    always_ff @(posedge GCLK_Pad or negedge RST_N_Pad) begin
        if (!RST_N_Pad) begin
            s0_a_q    <= '0;
            s0_b_q    <= '0;
            s0_cin_q  <= 1'b0;
            s1_gp_q   <= '0;
            s1_cin_q  <= 1'b0;
            s2_gp_q   <= '0;
            s2_p_q    <= '0;
            s2_cin_q  <= 1'b0;
            s3_gp_q   <= '0;
            s3_p_q    <= '0;
            s3_cin_q  <= 1'b0;
            s4_sum_q  <= '0;
            s4_cout_q <= 1'b0;
        end else begin
            s0_a_q    <= op_a;
            s0_b_q    <= op_b;
            s0_cin_q  <= op_cin;
            s1_gp_q   <= s1_gp_d;
            s1_cin_q  <= s0_cin_q;
            s2_gp_q   <= s2_gp_d;
            s2_p_q    <= s2_p_d;
            s2_cin_q  <= s1_cin_q;
            s3_gp_q   <= s3_gp_d;
            s3_p_q    <= s2_p_q;
            s3_cin_q  <= s2_cin_q;
            s4_sum_q  <= s4_sum_d;
            s4_cout_q <= s4_cout_d;
        end
    end

    // Group propagates after the last prefix level feed nothing; synthesis
    // removes them.
    logic unused_p;
    assign unused_p = ^{s3_gp_q[3].p, s3_gp_q[2].p, s3_gp_q[1].p, s3_gp_q[0].p};

    assign sum0_Pad = s4_sum_q[0];
    assign sum1_Pad = s4_sum_q[1];
    assign sum2_Pad = s4_sum_q[2];
    assign sum3_Pad = s4_sum_q[3];
    assign cout_Pad = s4_cout_q;

endmodule

`default_nettype wire

// File: tb/tb_ksa4_pipelined_adder.sv
//==============================================================================
// Module      : tb_ksa4_pipelined_adder
// Description : Scoreboard bench for ksa4_pipelined_adder. Each sampled
//               operand set pushes A+B+cin; the entry four edges older is
//               popped and compared after every rising edge.
//               With PULSE_CAPTURE_EN, operands are applied as 2-unit pulses.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ksa4_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pad_a = '0;
    logic [3:0] pad_b = '0;
    logic       pad_cin = 1'b0;
    logic       sum0, sum1, sum2, sum3, cout;
    logic [4:0] dut_out;

    // Operand set applied in the current cycle (what the next edge samples).
    logic [3:0] s_a = '0;
    logic [3:0] s_b = '0;
    logic       s_cin = 1'b0;
    string      s_tag = "idle";

    typedef struct {
        string      tag;
        logic [4:0] res;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t cur;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign dut_out = {cout, sum3, sum2, sum1, sum0};

    ksa4_pipelined_adder dut (
        .GCLK_Pad  (clk),
        .RST_N_Pad (rst_n),
        .a0_Pad    (pad_a[0]),
        .a1_Pad    (pad_a[1]),
        .a2_Pad    (pad_a[2]),
        .a3_Pad    (pad_a[3]),
        .b0_Pad    (pad_b[0]),
        .b1_Pad    (pad_b[1]),
        .b2_Pad    (pad_b[2]),
        .b3_Pad    (pad_b[3]),
        .cin_Pad   (pad_cin),
        .sum0_Pad  (sum0),
        .sum1_Pad  (sum1),
        .sum2_Pad  (sum2),
        .sum3_Pad  (sum3),
        .cout_Pad  (cout)
    );

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got cout,sum=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one operand set for the coming edge, starting at the falling edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input string tag);
        @(negedge clk);
        s_a   = a;
        s_b   = b;
        s_cin = c;
        s_tag = tag;
`ifdef PULSE_CAPTURE_EN
        pad_a   = a;
        pad_b   = b;
        pad_cin = c;
        #2;
        pad_a   = '0;
        pad_b   = '0;
        pad_cin = 1'b0;
`else
        pad_a   = a;
        pad_b   = b;
        pad_cin = c;
`endif
    endtask

    // Scoreboard: push at each sampling edge, pop the entry from four edges ago.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            cur = '{tag: "in_reset", res: 5'd0};
        end else begin
            sb.push_back('{tag: s_tag,
                           res: {1'b0, s_a} + {1'b0, s_b} + {4'd0, s_cin}});
            if (sb.size() > 4) cur = sb.pop_front();
            else               cur = '{tag: "fill", res: 5'd0};
        end
        #1;
        check_eq(cur.tag, dut_out, cur.res);
    end

    // Reset must clear outputs without waiting for a clock and drop in-flight work.
    always @(negedge rst_n) begin
        sb.delete();
        cur = '{tag: "in_reset", res: 5'd0};
        #1;
        check_eq("async_reset", dut_out, 5'd0);
    end

    initial begin
        rst_n = 1'b0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), "rst_rand");
        end
        drive(4'd0, 4'd0, 1'b0, "zero");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(4'd0, 4'd0, 1'b0, "zero");

        // Single operation, then the pipe drains to zero
        drive(4'd1, 4'd5, 1'b1, "1+5+1");
        for (int i = 0; i < 5; i++) drive(4'd0, 4'd0, 1'b0, "zero");

        // Back-to-back operations
        drive(4'd11, 4'd14, 1'b0, "11+14+0");
        drive(4'd6,  4'd11, 1'b1, "6+11+1");
        drive(4'd15, 4'd2,  1'b1, "15+2+1");
        for (int i = 0; i < 5; i++) drive(4'd0, 4'd0, 1'b0, "zero");

        // Full-propagate chains
        drive(4'd15, 4'd0,  1'b1, "15+0+1");
        drive(4'd15, 4'd15, 1'b1, "15+15+1");
        for (int i = 0; i < 5; i++) drive(4'd0, 4'd0, 1'b0, "zero");

        // Reset two cycles after issue: 9+9 must never emerge
        drive(4'd9, 4'd9, 1'b0, "9+9_dropped");
        drive(4'd0, 4'd0, 1'b0, "zero");
        drive(4'd0, 4'd0, 1'b0, "zero");
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'd0, 4'd0, 1'b0, "zero");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drive(4'd0, 4'd0, 1'b0, "zero");

        // Reset while a nonzero result sits on the outputs
        drive(4'd15, 4'd15, 1'b1, "async_src");
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        drive(4'd0, 4'd0, 1'b0, "zero");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drive(4'd0, 4'd0, 1'b0, "zero");

        // Random back-to-back burst
        for (int i = 0; i < 24; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), "rand");
        end
        for (int i = 0; i < 6; i++) drive(4'd0, 4'd0, 1'b0, "zero");

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
